homeostasis_scheduler: RTL

Time-multiplexed homeostasis controller for the spike-rate datapath. On each epoch trigger it walks the per-neuron rate bus one index per enabled cycle and accumulates with a single adder, so no N-input adder tree is built. It forms the mean by shift and drives a slew-limited dopamine level through a programmable hysteresis band. It sits between the bank of per-neuron rate estimators and the plasticity/modulation logic that consumes `dopamine_o`.

---
 rtl/homeostasis_scheduler.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/homeostasis_scheduler.sv
// homeostasis_scheduler
// Time-multiplexed homeostasis controller. On an epoch trigger it scans the
// per-neuron rate bus one entry per enabled cycle with a single accumulator,
// forms the mean by shift, and slews a dopamine level through a hysteresis band.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   clk_en          global advance enable (all state frozen when low)
//   start_i         epoch trigger, honoured in IDLE only
//   rate_sel_o      index of the rate entry requested this cycle (0 outside SCAN)
//   rate_i          rate entry selected by rate_sel_o (combinational, same cycle)
//   target_i        target mean rate
//   band_i          hysteresis half-width
//   busy_o          epoch in progress
//   done_o          one-cycle pulse when dopamine_o is updated
//   mean_o          last computed mean rate
//   dopamine_o      modulation level (neutral 128)
//   dbg_status      registered {state, 6'b0, dopamine_o, mean_o}
module homeostasis_scheduler #(
    parameter int unsigned N_NEURON = 64,
    parameter int unsigned RATE_W   = 16,
    parameter int unsigned STEP     = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        clk_en,
    input  logic                        start_i,
    output logic [$clog2(N_NEURON)-1:0] rate_sel_o,
    input  logic [RATE_W-1:0]           rate_i,
    input  logic [15:0]                 target_i,
    input  logic [15:0]                 band_i,
    output logic                        busy_o,
    output logic                        done_o,
    output logic [15:0]                 mean_o,
    output logic [7:0]                  dopamine_o,
    output logic [31:0]                 dbg_status
);

    localparam int unsigned IDX_W = $clog2(N_NEURON);
    localparam int unsigned ACC_W = RATE_W + IDX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        DIV    = 2'd2,
        UPDATE = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              busy_d, done_d;
    logic [15:0]       mean_d;
    logic [7:0]        dop_d;

    logic [15:0]       lo_c, hi_c;
    logic [16:0]       hi_sum_c;
    logic [8:0]        dop_up_c;

    // The scan index register drives the select port directly; it is
    // cleared on leaving SCAN so the port reads 0 at all other times.
    assign rate_sel_o = idx_q;

    // Saturating hysteresis thresholds and saturating dopamine increment.
    always_comb begin
        hi_sum_c = {1'b0, target_i} + {1'b0, band_i};
        hi_c     = hi_sum_c[16] ? 16'hFFFF : hi_sum_c[15:0];
        lo_c     = (band_i > target_i) ? 16'd0 : (target_i - band_i);
        dop_up_c = {1'b0, dopamine_o} + 9'(STEP);
    end

    // Next-state and next-value logic.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        busy_d  = busy_o;
        done_d  = 1'b0;
        mean_d  = mean_o;
        dop_d   = dopamine_o;

        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = SCAN;
                    acc_d   = '0;
                    idx_d   = '0;
                    busy_d  = 1'b1;
                end
            end
            SCAN: begin
                acc_d = acc_q + ACC_W'(rate_i);
                if (idx_q == IDX_W'(N_NEURON - 1)) begin
                    state_d = DIV;
                    idx_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            DIV: begin
                mean_d  = 16'(acc_q >> IDX_W);
                state_d = UPDATE;
            end
            UPDATE: begin
                if (mean_o < lo_c) begin
                    dop_d = dop_up_c[8] ? 8'hFF : dop_up_c[7:0];
                end else if (mean_o > hi_c) begin
                    dop_d = (dopamine_o < 8'(STEP)) ? 8'd0 : (dopamine_o - 8'(STEP));
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset wins over clk_en.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            acc_q      <= '0;
            idx_q      <= '0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
            mean_o     <= 16'd0;
            dopamine_o <= 8'd128;
            dbg_status <= 32'd0;
        end else if (clk_en) begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            idx_q      <= idx_d;
            busy_o     <= busy_d;
            done_o     <= done_d;
            mean_o     <= mean_d;
            dopamine_o <= dop_d;
            dbg_status <= {state_q, 6'b0, dopamine_o, mean_o};
        end
    end

endmodule
